// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone arbiter/interconnect.
package wb_pkg;

    // Interconnect ownership state: nobody owns the bus, or one master does.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Ceiling log2, used to size indices and counters from parameters.
    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: scans requests starting one past the
// last granted index, wrapping modulo NM, and returns the first requester.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NM = 2,
    localparam int IW = (NM > 1) ? int'(log2c(NM)) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [NM-1:0] grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Rotating priority scan; the first hit after 'last' wins.
    always_comb begin
        int   j;
        logic hit;
        grant = {NM{1'b0}};
        idx   = {IW{1'b0}};
        valid = 1'b0;
        j     = 0;
        hit   = 1'b0;
        for (int i = 1; i <= NM; i++) begin
            j        = (int'(last) + i) % NM;
            hit      = !valid && req[j];
            grant[j] = grant[j] | hit;
            idx      = hit ? IW'(j) : idx;
            valid    = valid | hit;
        end
    end

endmodule

// File: rtl/wb_arb_intercon.sv
// Wishbone classic shared-bus interconnect: NM masters, NS slaves,
// round-robin arbitration, mask/base address decode, internal error for
// unmapped addresses and an optional per-transfer timeout.
module wb_arb_intercon
    import wb_pkg::*;
#(
    parameter int              NM        = 2,
    parameter int              NS        = 5,
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter int              BW        = 8,
    parameter logic [NS*BW-1:0] ADR_MASK  = {(NS*BW){1'b1}},
    parameter logic [NS*BW-1:0] SLAVE_ADR = {(NS*BW){1'b0}},
    parameter int              TIMEOUT   = 255
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    input  logic [NM*AW-1:0]     i_wbm_adr,
    input  logic [NM*DW-1:0]     i_wbm_dat,
    input  logic [NM*DW/8-1:0]   i_wbm_sel,
    input  logic [NM-1:0]        i_wbm_we,
    input  logic [NM-1:0]        i_wbm_cyc,
    input  logic [NM-1:0]        i_wbm_stb,
    output logic [DW-1:0]        o_wbm_dat,
    output logic [NM-1:0]        o_wbm_ack,
    output logic [NM-1:0]        o_wbm_err,
    output logic [AW-1:0]        o_wbs_adr,
    output logic [DW-1:0]        o_wbs_dat,
    output logic [DW/8-1:0]      o_wbs_sel,
    output logic                 o_wbs_we,
    output logic [NS-1:0]        o_wbs_cyc,
    output logic [NS-1:0]        o_wbs_stb,
    input  logic [NS*DW-1:0]     i_wbs_dat,
    input  logic [NS-1:0]        i_wbs_ack,
    input  logic [NS-1:0]        i_wbs_err,
    output logic [NM-1:0]        o_grant,
    output logic                 o_timeout
);

    localparam int IW = (NM > 1) ? int'(log2c(NM)) : 1;
    localparam int SW = (NS > 1) ? int'(log2c(NS)) : 1;
    localparam int TW = (TIMEOUT > 0) ? int'(log2c(TIMEOUT + 1)) : 1;
    localparam int SB = DW / 8;

    state_t          state_r, state_s;
    logic [NM-1:0]   grant_r, grant_s;
    logic [IW-1:0]   gidx_r, gidx_s;
    logic [IW-1:0]   last_r, last_s;

    logic [NM-1:0]   arb_grant_s;
    logic [IW-1:0]   arb_idx_s;
    logic            arb_valid_s;

    logic [AW-1:0]   m_adr_s;
    logic [DW-1:0]   m_dat_s;
    logic [SB-1:0]   m_sel_s;
    logic            m_we_s;
    logic            m_cyc_s;
    logic            gstb_s;

    logic [NS-1:0]   match_s;
    logic [NS-1:0]   sel_oh_s;
    logic [SW-1:0]   sel_idx_s;
    logic            sel_valid_s;

    logic [DW-1:0]   s_dat_s;
    logic            ack_s;
    logic            serr_s;
    logic            err_out_s;
    logic            nm_err_r;
    logic            to_err_r;

    wb_rr_arbiter #(.NM(NM)) u_arb (
        .req   (i_wbm_cyc),
        .last  (last_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    // State, grant and rotation pointer registers.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_r <= IDLE;
            grant_r <= {NM{1'b0}};
            gidx_r  <= {IW{1'b0}};
            last_r  <= IW'(NM - 1);
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            gidx_r  <= gidx_s;
            last_r  <= last_s;
        end
    end

    // Next-state logic: grant on request, hold while the owner keeps cyc.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        gidx_s  = gidx_r;
        last_s  = last_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    state_s = BUSY;
                    grant_s = arb_grant_s;
                    gidx_s  = arb_idx_s;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!m_cyc_s) begin
                    state_s = IDLE;
                    grant_s = {NM{1'b0}};
                    last_s  = gidx_r;
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = {NM{1'b0}};
            end
        endcase
    end

    // Select the granted master's request signals; all zero without a grant.
    always_comb begin
        m_adr_s = {AW{1'b0}};
        m_dat_s = {DW{1'b0}};
        m_sel_s = {SB{1'b0}};
        m_we_s  = 1'b0;
        m_cyc_s = 1'b0;
        gstb_s  = 1'b0;
        for (int m = 0; m < NM; m++) begin
            m_adr_s = m_adr_s | (i_wbm_adr[m*AW +: AW] & {AW{grant_r[m]}});
            m_dat_s = m_dat_s | (i_wbm_dat[m*DW +: DW] & {DW{grant_r[m]}});
            m_sel_s = m_sel_s | (i_wbm_sel[m*SB +: SB] & {SB{grant_r[m]}});
            m_we_s  = m_we_s  | (i_wbm_we[m]  & grant_r[m]);
            m_cyc_s = m_cyc_s | (i_wbm_cyc[m] & grant_r[m]);
            gstb_s  = gstb_s  | (i_wbm_cyc[m] & i_wbm_stb[m] & grant_r[m]);
        end
    end

    // Per-slave address match; slave 0 owns the most significant map slice.
    for (genvar s = 0; s < NS; s++) begin : g_match
        assign match_s[s] = (|grant_r) &&
            (((m_adr_s[AW-1 -: BW] ^ SLAVE_ADR[(NS-1-s)*BW +: BW]) &
              ADR_MASK[(NS-1-s)*BW +: BW]) == {BW{1'b0}});
        assign sel_oh_s[s] = sel_valid_s && (sel_idx_s == SW'(s));
    end

    // Lowest-index matching slave wins when maps overlap.
    always_comb begin
        sel_idx_s   = {SW{1'b0}};
        sel_valid_s = 1'b0;
        for (int s = 0; s < NS; s++) begin
            sel_idx_s   = (match_s[s] && !sel_valid_s) ? SW'(s) : sel_idx_s;
            sel_valid_s = sel_valid_s | match_s[s];
        end
    end

    // Response mux from the selected slave; zero when nothing is selected.
    always_comb begin
        s_dat_s = {DW{1'b0}};
        for (int s = 0; s < NS; s++) begin
            s_dat_s = s_dat_s | (i_wbs_dat[s*DW +: DW] & {DW{sel_oh_s[s]}});
        end
    end

    assign ack_s     = (|(i_wbs_ack & sel_oh_s)) & gstb_s;
    assign serr_s    = (|(i_wbs_err & sel_oh_s)) & gstb_s;
    // A real acknowledge in the same cycle suppresses an internal error.
    assign err_out_s = serr_s | ((nm_err_r | to_err_r) & ~ack_s);

    // Unmapped access: one-cycle error, then one quiet cycle before repeating.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            nm_err_r <= 1'b0;
        end else if ((state_r == BUSY) && gstb_s && !sel_valid_s && !nm_err_r) begin
            nm_err_r <= 1'b1;
        end else begin
            nm_err_r <= 1'b0;
        end
    end

    if (TIMEOUT > 0) begin : g_to
        logic [TW-1:0] to_cnt_r;

        // Count unanswered strobe cycles; fire once on reaching the limit.
        always_ff @(posedge i_wb_clk) begin
            if (i_wb_rst) begin
                to_cnt_r <= {TW{1'b0}};
                to_err_r <= 1'b0;
            end else if (!gstb_s || ack_s || err_out_s) begin
                to_cnt_r <= {TW{1'b0}};
                to_err_r <= 1'b0;
            end else if (to_cnt_r == TW'(TIMEOUT - 1)) begin
                to_cnt_r <= {TW{1'b0}};
                to_err_r <= 1'b1;
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
                to_err_r <= 1'b0;
            end
        end
    end else begin : g_no_to
        assign to_err_r = 1'b0;
    end

    assign o_wbs_adr = m_adr_s;
    assign o_wbs_dat = m_dat_s;
    assign o_wbs_sel = m_sel_s;
    assign o_wbs_we  = m_we_s;
    assign o_wbs_cyc = {NS{m_cyc_s}} & sel_oh_s;
    assign o_wbs_stb = {NS{gstb_s}} & sel_oh_s;
    assign o_wbm_dat = s_dat_s;
    assign o_wbm_ack = {NM{ack_s}} & grant_r;
    assign o_wbm_err = {NM{err_out_s}} & grant_r;
    assign o_grant   = grant_r;
    assign o_timeout = to_err_r & ~ack_s;

endmodule

// File: tb/tb_wb_arb_intercon.sv
// Randomized bench for wb_arb_intercon: two masters, five slaves mapped at
// 0x00/0x10/0x20/0x30/0x40 in the top address byte, 0x50 unmapped, TIMEOUT=4.
module tb_wb_arb_intercon;

    localparam int NM = 2;
    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic [NM*AW-1:0]  wbm_adr;
    logic [NM*DW-1:0]  wbm_dat;
    logic [NM*4-1:0]   wbm_sel;
    logic [NM-1:0]     wbm_we;
    logic [NM-1:0]     wbm_cyc;
    logic [NM-1:0]     wbm_stb;
    logic [DW-1:0]     m_dat;
    logic [NM-1:0]     m_ack;
    logic [NM-1:0]     m_err;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat;
    logic [3:0]        s_sel;
    logic              s_we;
    logic [NS-1:0]     s_cyc;
    logic [NS-1:0]     s_stb;
    logic [NS*DW-1:0]  wbs_dat;
    logic [NS-1:0]     wbs_ack;
    logic [NS-1:0]     wbs_err;
    logic [NM-1:0]     grant;
    logic              tmo;

    int n_cmp;
    int n_bad;
    int last_m;

    wb_arb_intercon #(
        .NM(NM), .NS(NS), .AW(AW), .DW(DW), .BW(8),
        .ADR_MASK(40'hFF_FFFF_FFFF),
        .SLAVE_ADR(40'h00_1020_3040),
        .TIMEOUT(4)
    ) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_wbm_adr(wbm_adr),
        .i_wbm_dat(wbm_dat),
        .i_wbm_sel(wbm_sel),
        .i_wbm_we (wbm_we),
        .i_wbm_cyc(wbm_cyc),
        .i_wbm_stb(wbm_stb),
        .o_wbm_dat(m_dat),
        .o_wbm_ack(m_ack),
        .o_wbm_err(m_err),
        .o_wbs_adr(s_adr),
        .o_wbs_dat(s_dat),
        .o_wbs_sel(s_sel),
        .o_wbs_we (s_we),
        .o_wbs_cyc(s_cyc),
        .o_wbs_stb(s_stb),
        .i_wbs_dat(wbs_dat),
        .i_wbs_ack(wbs_ack),
        .i_wbs_err(wbs_err),
        .o_grant  (grant),
        .o_timeout(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first requester after the last owner, wrapping.
    function automatic int rr_pick(input logic [NM-1:0] req);
        for (int i = 1; i <= NM; i++) begin
            int j;
            j = (last_m + i) % NM;
            if (req[j]) return j;
        end
        return 0;
    endfunction

    // One bus ownership: arbitration, then nb strobe transfers by the winner.
    // fr/fl force the target region (0..4 mapped, 5 unmapped) and the slave
    // wait count (>=5 never acks); -1 picks them at random.
    task automatic do_grant(input logic [NM-1:0] req, input int nb, input int fr, input int fl);
        int w;
        int r;
        int l;
        int endc;
        bit mapped;
        bit e_ack;
        bit e_err;
        bit e_to;
        logic [NS-1:0] sel;
        logic [31:0] a;
        logic [NS-1:0] na;
        logic [NS-1:0] ne;
        w = rr_pick(req);
        @(posedge clk); #1;
        wbm_adr = {$urandom, $urandom};
        wbm_dat = {$urandom, $urandom};
        wbm_sel = 8'($urandom);
        wbm_we  = 2'($urandom);
        wbm_cyc = req;
        wbm_stb = req;
        @(negedge clk);
        check_eq("idle_grant", grant, 0);
        check_eq("idle_stb", s_stb, 0);
        @(posedge clk); #1;
        for (int t = 0; t < nb; t++) begin
            if (t > 0) begin
                wbm_stb[w] = 1'b0;
                @(negedge clk);
                check_eq("gap_grant", grant, 64'(1) << w);
                check_eq("gap_stb", s_stb, 0);
                check_eq("gap_ack", m_ack, 0);
                check_eq("gap_err", m_err, 0);
                @(posedge clk); #1;
            end
            r = (fr >= 0) ? fr : int'($urandom_range(0, 5));
            l = (fl >= 0) ? fl : int'($urandom_range(0, 5));
            a = {8'(r * 16), 24'($urandom)};
            wbm_adr[w*AW +: AW] = a;
            wbm_stb[w] = 1'b1;
            for (int s = 0; s < NS; s++) wbs_dat[s*DW +: DW] = $urandom;
            mapped = (r < 5);
            sel    = mapped ? NS'(1 << r) : '0;
            endc   = !mapped ? 4 : ((l <= 4) ? l + 1 : 5);
            for (int c = 1; c <= endc; c++) begin
                e_ack = mapped && (l <= 4) && (c == l + 1);
                e_err = mapped ? ((l >= 5) && (c == 5)) : ((c == 2) || (c == 4));
                e_to  = mapped && (l >= 5) && (c == 5);
                na = NS'($urandom) & ~sel;
                ne = NS'($urandom) & ~sel;
                wbs_ack = (e_ack ? sel : '0) | na;
                wbs_err = ne;
                @(negedge clk);
                check_eq("grant", grant, 64'(1) << w);
                check_eq("slv_stb", s_stb, sel);
                check_eq("slv_cyc", s_cyc, sel);
                check_eq("ack", m_ack, e_ack ? (64'(1) << w) : 64'(0));
                check_eq("err", m_err, e_err ? (64'(1) << w) : 64'(0));
                check_eq("timeout", tmo, e_to);
                if (c == 1) begin
                    check_eq("slv_adr", s_adr, a);
                    check_eq("slv_we", s_we, wbm_we[w]);
                end
                if (e_ack) check_eq("rdata", m_dat, wbs_dat[r*DW +: DW]);
                if (!mapped) check_eq("rdata_nomap", m_dat, 0);
                @(posedge clk); #1;
            end
            wbs_ack = '0;
            wbs_err = '0;
        end
        wbm_stb = '0;
        wbm_cyc = '0;
        last_m  = w;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        last_m  = NM - 1;
        rst     = 1'b1;
        wbm_adr = '0;
        wbm_dat = '0;
        wbm_sel = '0;
        wbm_we  = '0;
        wbm_cyc = '0;
        wbm_stb = '0;
        wbs_dat = '0;
        wbs_ack = '0;
        wbs_err = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_cyc", s_cyc, 0);
        check_eq("rst_stb", s_stb, 0);
        check_eq("rst_ack", m_ack, 0);
        check_eq("rst_err", m_err, 0);
        check_eq("rst_to", tmo, 0);
        check_eq("rst_dat", m_dat, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous requests after reset, then strict alternation.
        do_grant(2'b11, 1, 1, 2);
        do_grant(2'b11, 1, -1, -1);
        do_grant(2'b11, 1, -1, -1);
        do_grant(2'b11, 1, -1, -1);
        // Unmapped address, pure timeout, ack colliding with timeout.
        do_grant(2'b11, 1, 5, 0);
        do_grant(2'b11, 1, 3, 5);
        do_grant(2'b11, 1, 3, 4);
        // Block cycle to the UART while the other master waits.
        do_grant(2'b11, 3, 2, 1);
        do_grant(2'b01, 1, 0, 0);

        for (int k = 0; k < 60; k++) begin
            logic [NM-1:0] rq;
            rq = NM'($urandom_range(1, 3));
            do_grant(rq, int'($urandom_range(1, 3)), -1, -1);
        end

        // Reset while master 1 owns the bus mid-transfer.
        @(posedge clk); #1;
        wbm_cyc = 2'b10;
        wbm_stb = 2'b10;
        wbm_adr[AW +: AW] = 32'h4000_0010;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("pre_rst_grant", grant, 2'b10);
        check_eq("pre_rst_stb", s_stb, 5'b10000);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mid_rst_cyc", s_cyc, 0);
        check_eq("mid_rst_stb", s_stb, 0);
        check_eq("mid_rst_grant", grant, 0);
        check_eq("mid_rst_ack", m_ack, 0);
        check_eq("mid_rst_err", m_err, 0);
        @(posedge clk); #1;
        rst     = 1'b0;
        wbm_cyc = '0;
        wbm_stb = '0;
        last_m  = NM - 1;
        do_grant(2'b11, 1, -1, -1);
        check_eq("post_rst_winner", last_m, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
